// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor: 2-bit saturating-counter BHT with combinational
// fetch lookup, execute-stage branch resolution, and saturating perf counters.
module branch_predict_unit #(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 6,
  parameter int CNT_W    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] f_pc,
  output logic            f_pred_taken,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic            ex_pred_taken,
  output logic            ex_taken,
  output logic            ex_mispredict,
  output logic [CNT_W-1:0] perf_branches,
  output logic [CNT_W-1:0] perf_mispredicts
);

  localparam int ENTRIES = 1 << IDX_BITS;

  function automatic logic [1:0] cnt2_update(input logic [1:0] c, input logic up);
    logic [1:0] r;
    r = c;
    if (up && c != 2'b11)
      r = c + 2'b01;
    else if (!up && c != 2'b00)
      r = c - 2'b01;
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] perf_sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic [1:0]          bht_q [ENTRIES];
  logic [1:0]          bht_d [ENTRIES];
  logic [CNT_W-1:0]    perf_branches_q, perf_branches_d;
  logic [CNT_W-1:0]    perf_mispredicts_q, perf_mispredicts_d;

  logic [IDX_BITS-1:0] f_idx;
  logic [IDX_BITS-1:0] ex_idx;
  logic signed [XLEN-1:0] rs1_s;
  logic signed [XLEN-1:0] rs2_s;
  logic                taken_raw;
  logic                resolve;
  logic                unused_pc_bits;

  assign f_idx  = f_pc[IDX_BITS+1:2];
  assign ex_idx = ex_pc[IDX_BITS+1:2];
  assign rs1_s  = ex_rs1;
  assign rs2_s  = ex_rs2;

  assign unused_pc_bits = ^{f_pc[XLEN-1:IDX_BITS+2], f_pc[1:0],
                            ex_pc[XLEN-1:IDX_BITS+2], ex_pc[1:0]};

  // Lookup reads the registered table only, so a same-cycle update is not bypassed.
  assign f_pred_taken = bht_q[f_idx][1];

  always_comb begin
    taken_raw = 1'b0;
    case (ex_funct3)
      3'b000:  taken_raw = (ex_rs1 == ex_rs2);
      3'b001:  taken_raw = (ex_rs1 != ex_rs2);
      3'b100:  taken_raw = (rs1_s <  rs2_s);
      3'b101:  taken_raw = (rs1_s >= rs2_s);
      3'b110:  taken_raw = (ex_rs1 <  ex_rs2);
      3'b111:  taken_raw = (ex_rs1 >= ex_rs2);
      default: taken_raw = 1'b0;
    endcase
  end

  assign resolve = ex_valid && ex_is_branch &&
                   (ex_funct3 != 3'b010) && (ex_funct3 != 3'b011);

  assign ex_taken      = resolve && taken_raw;
  assign ex_mispredict = resolve && (taken_raw ^ ex_pred_taken);

  always_comb begin
    bht_d              = bht_q;
    perf_branches_d    = perf_branches_q;
    perf_mispredicts_d = perf_mispredicts_q;
    if (resolve) begin
      bht_d[ex_idx]   = cnt2_update(bht_q[ex_idx], taken_raw);
      perf_branches_d = perf_sat_inc(perf_branches_q);
      if (ex_mispredict)
        perf_mispredicts_d = perf_sat_inc(perf_mispredicts_q);
    end
  end

  // Reset wins over a concurrent resolve: all entries return to weak-not-taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++)
        bht_q[i] <= 2'b01;
      perf_branches_q    <= '0;
      perf_mispredicts_q <= '0;
    end else begin
      bht_q              <= bht_d;
      perf_branches_q    <= perf_branches_d;
      perf_mispredicts_q <= perf_mispredicts_d;
    end
  end

  assign perf_branches    = perf_branches_q;
  assign perf_mispredicts = perf_mispredicts_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed testbench for branch_predict_unit: default instance plus a
// CNT_W=4 instance sharing the same stimulus for counter saturation.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] f_pc = '0;
  logic        f_pred_taken;
  logic        ex_valid = 1'b0;
  logic        ex_is_branch = 1'b0;
  logic [31:0] ex_pc = '0;
  logic [2:0]  ex_funct3 = '0;
  logic [31:0] ex_rs1 = '0;
  logic [31:0] ex_rs2 = '0;
  logic        ex_pred_taken = 1'b0;
  logic        ex_taken;
  logic        ex_mispredict;
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;

  logic        f_pred_taken4;
  logic        ex_taken4;
  logic        ex_mispredict4;
  logic [3:0]  perf_branches4;
  logic [3:0]  perf_mispredicts4;

  int assertions = 0;
  int failures   = 0;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk(clk), .reset(reset), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
    .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_pred_taken(ex_pred_taken), .ex_taken(ex_taken),
    .ex_mispredict(ex_mispredict), .perf_branches(perf_branches),
    .perf_mispredicts(perf_mispredicts)
  );

  branch_predict_unit #(.XLEN(32), .IDX_BITS(6), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .f_pc(f_pc), .f_pred_taken(f_pred_taken4),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
    .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_pred_taken(ex_pred_taken), .ex_taken(ex_taken4),
    .ex_mispredict(ex_mispredict4), .perf_branches(perf_branches4),
    .perf_mispredicts(perf_mispredicts4)
  );

  task automatic set_idle();
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_pc = '0; ex_funct3 = 3'b000;
    ex_rs1 = '0; ex_rs2 = '0; ex_pred_taken = 1'b0;
  endtask

  task automatic set_branch(input logic [31:0] pc, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic pred);
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = pc; ex_funct3 = f3;
    ex_rs1 = a; ex_rs2 = b; ex_pred_taken = pred;
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] pcs [4] = '{32'h100, 32'h0, 32'h204, 32'hFC};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      f_pc = pcs[i];
      #1;
      assertions++;
      if (f_pred_taken !== 1'b0) begin
        failures++;
        $display("FAIL reset_pred pc=%h got=%b exp=0", pcs[i], f_pred_taken);
      end
    end
    assertions++;
    if (perf_branches !== 32'd0 || perf_mispredicts !== 32'd0) begin
      failures++;
      $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_branches, perf_mispredicts);
    end
  endtask

  task automatic test_taken_train();
    logic exp_pred [3] = '{1'b0, 1'b1, 1'b1};
    do_reset();
    f_pc = 32'h100;
    for (int i = 0; i < 3; i++) begin
      set_branch(32'h100, 3'b000, 32'd5, 32'd5, 1'b0);
      #1;
      assertions++;
      if (ex_taken !== 1'b1 || ex_mispredict !== 1'b1) begin
        failures++;
        $display("FAIL train_resolve cyc=%0d got=%b%b exp=11", i, ex_taken, ex_mispredict);
      end
      assertions++;
      if (f_pred_taken !== exp_pred[i]) begin
        failures++;
        $display("FAIL train_pred cyc=%0d got=%b exp=%b", i, f_pred_taken, exp_pred[i]);
      end
      @(negedge clk);
    end
    set_idle();
    #1;
    assertions++;
    if (perf_branches !== 32'd3 || perf_mispredicts !== 32'd3) begin
      failures++;
      $display("FAIL train_perf got=%0d/%0d exp=3/3", perf_branches, perf_mispredicts);
    end
    // Counter saturated at 11: one not-taken only drops to 10 (still taken).
    set_branch(32'h100, 3'b001, 32'd7, 32'd7, 1'b1);
    #1;
    assertions++;
    if (ex_taken !== 1'b0 || ex_mispredict !== 1'b1) begin
      failures++;
      $display("FAIL nt_resolve got=%b%b exp=01", ex_taken, ex_mispredict);
    end
    @(negedge clk);
    set_idle();
    #1;
    assertions++;
    if (f_pred_taken !== 1'b1) begin
      failures++;
      $display("FAIL sat_hi got=%b exp=1", f_pred_taken);
    end
    set_branch(32'h100, 3'b001, 32'd7, 32'd7, 1'b1);
    @(negedge clk);
    set_idle();
    #1;
    assertions++;
    if (f_pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL dec_to_wnt got=%b exp=0", f_pred_taken);
    end
  endtask

  task automatic test_signed_unsigned();
    logic [2:0]  f3s  [8] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b000, 3'b001, 3'b000, 3'b110};
    logic [31:0] as   [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000005, 32'h80000000};
    logic [31:0] bs   [8] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'h5, 32'h7FFFFFFF};
    logic        exp  [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_branch(32'h400, f3s[i], as[i], bs[i], 1'b0);
      #1;
      assertions++;
      if (ex_taken !== exp[i] || ex_mispredict !== exp[i]) begin
        failures++;
        $display("FAIL cmp f3=%b a=%h b=%h got=%b%b exp=%b%b",
                 f3s[i], as[i], bs[i], ex_taken, ex_mispredict, exp[i], exp[i]);
      end
      @(negedge clk);
    end
    set_idle();
  endtask

  task automatic test_bubble();
    do_reset();
    f_pc = 32'h100;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: set_branch(32'h100, 3'b010, 32'd5, 32'd5, 1'b1);
        1: set_branch(32'h100, 3'b011, 32'd5, 32'd5, 1'b1);
        2: begin set_branch(32'h100, 3'b000, 32'd5, 32'd5, 1'b1); ex_valid = 1'b0; end
        default: begin set_branch(32'h100, 3'b000, 32'd5, 32'd5, 1'b1); ex_is_branch = 1'b0; end
      endcase
      #1;
      assertions++;
      if (ex_taken !== 1'b0 || ex_mispredict !== 1'b0) begin
        failures++;
        $display("FAIL bubble case=%0d got=%b%b exp=00", i, ex_taken, ex_mispredict);
      end
      @(negedge clk);
    end
    set_idle();
    #1;
    assertions++;
    if (perf_branches !== 32'd0 || perf_mispredicts !== 32'd0 || f_pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL bubble_state got=%0d/%0d/%b exp=0/0/0",
               perf_branches, perf_mispredicts, f_pred_taken);
    end
  endtask

  task automatic test_collision();
    do_reset();
    f_pc = 32'h200;
    set_branch(32'h200, 3'b000, 32'd1, 32'd1, 1'b0);
    #1;
    assertions++;
    if (f_pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL collide_same got=%b exp=0", f_pred_taken);
    end
    @(negedge clk);
    set_idle();
    #1;
    assertions++;
    if (f_pred_taken !== 1'b1) begin
      failures++;
      $display("FAIL collide_next got=%b exp=1", f_pred_taken);
    end
    do_reset();
    set_branch(32'h300, 3'b000, 32'd1, 32'd1, 1'b0);
    @(negedge clk);
    set_idle();
    f_pc = 32'h200;
    #1;
    assertions++;
    if (f_pred_taken !== 1'b1) begin
      failures++;
      $display("FAIL alias_200 got=%b exp=1", f_pred_taken);
    end
    f_pc = 32'h204;
    #1;
    assertions++;
    if (f_pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL alias_204 got=%b exp=0", f_pred_taken);
    end
  endtask

  task automatic test_reset_collision();
    do_reset();
    f_pc = 32'h200;
    set_branch(32'h200, 3'b000, 32'd1, 32'd1, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    set_branch(32'h200, 3'b000, 32'd1, 32'd1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    set_idle();
    #1;
    assertions++;
    if (f_pred_taken !== 1'b0 || perf_branches !== 32'd0 || perf_mispredicts !== 32'd0) begin
      failures++;
      $display("FAIL rst_collide got=%b/%0d/%0d exp=0/0/0",
               f_pred_taken, perf_branches, perf_mispredicts);
    end
    // Entry must be 01, so one taken resolve flips the prediction.
    set_branch(32'h200, 3'b000, 32'd1, 32'd1, 1'b0);
    @(negedge clk);
    set_idle();
    #1;
    assertions++;
    if (f_pred_taken !== 1'b1) begin
      failures++;
      $display("FAIL rst_entry_01 got=%b exp=1", f_pred_taken);
    end
  endtask

  task automatic test_perf_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_branch(32'h40 + 32'(i * 4), 3'b000, 32'd9, 32'd9, 1'b0);
      @(negedge clk);
    end
    set_idle();
    #1;
    assertions++;
    if (perf_branches4 !== 4'd15 || perf_mispredicts4 !== 4'd15) begin
      failures++;
      $display("FAIL perf_sat4 got=%0d/%0d exp=15/15", perf_branches4, perf_mispredicts4);
    end
    assertions++;
    if (perf_branches !== 32'd20 || perf_mispredicts !== 32'd20) begin
      failures++;
      $display("FAIL perf_20 got=%0d/%0d exp=20/20", perf_branches, perf_mispredicts);
    end
  endtask

  initial begin
    test_reset();
    test_taken_train();
    test_signed_unsigned();
    test_bubble();
    test_collision();
    test_reset_collision();
    test_perf_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
